// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: shared constants and helpers for the VGA scan-out slice.
//   - default 640x480@60 timing set (pixel clocks / lines)
//   - h_total / v_total derivation helpers
//   - 8-entry colour-bar table used by the optional test pattern
package vga_timing_pkg;

    // Default 640x480@60 horizontal timing (pixel clocks)
    localparam int unsigned H_SYNC_DEF   = 96;
    localparam int unsigned H_BP_DEF     = 48;
    localparam int unsigned H_ACTIVE_DEF = 640;
    localparam int unsigned H_FP_DEF     = 16;

    // Default 640x480@60 vertical timing (lines)
    localparam int unsigned V_SYNC_DEF   = 2;
    localparam int unsigned V_BP_DEF     = 33;
    localparam int unsigned V_ACTIVE_DEF = 480;
    localparam int unsigned V_FP_DEF     = 10;

    localparam int unsigned RGB_W  = 12;
    localparam int unsigned N_BARS = 8;

    // Colour bars, index 0 in the LSBs: white, yellow, cyan, green,
    // magenta, red, blue, black
    localparam logic [N_BARS*RGB_W-1:0] BAR_TABLE = {
        12'h000, 12'h00F, 12'hF00, 12'hF0F,
        12'h0F0, 12'h0FF, 12'hFF0, 12'hFFF
    };

    function automatic int unsigned h_total(input int unsigned sync,
                                            input int unsigned bp,
                                            input int unsigned act,
                                            input int unsigned fp);
        return sync + bp + act + fp;
    endfunction

    function automatic int unsigned v_total(input int unsigned sync,
                                            input int unsigned bp,
                                            input int unsigned act,
                                            input int unsigned fp);
        return sync + bp + act + fp;
    endfunction

    function automatic logic [RGB_W-1:0] bar_colour(input logic [2:0] idx);
        return BAR_TABLE[32'(idx)*RGB_W +: RGB_W];
    endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: horizontal/vertical counters for a VGA mode.
//   clk, rstn        pixel clock, synchronous active-low reset
//   active_c         hcnt/vcnt inside the visible window
//   line_first_c     hcnt is the first visible column
//   line_last_c      hcnt is the last visible column
//   hs_c, vs_c       raw sync levels (SYNC_POL while in sync)
//   frame_start_c    hcnt = 0 and vcnt = 0
// All *_c outputs are combinational decodes of the counter registers; the
// parent registers them to form its counter stage.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_SYNC   = H_SYNC_DEF,
    parameter int unsigned H_BP     = H_BP_DEF,
    parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
    parameter int unsigned H_FP     = H_FP_DEF,
    parameter int unsigned V_SYNC   = V_SYNC_DEF,
    parameter int unsigned V_BP     = V_BP_DEF,
    parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
    parameter int unsigned V_FP     = V_FP_DEF,
    parameter bit          SYNC_POL = 1'b1
) (
    input  logic clk,
    input  logic rstn,
    output logic active_c,
    output logic line_first_c,
    output logic line_last_c,
    output logic hs_c,
    output logic vs_c,
    output logic frame_start_c
);

    localparam int unsigned H_TOTAL = h_total(H_SYNC, H_BP, H_ACTIVE, H_FP);
    localparam int unsigned V_TOTAL = v_total(V_SYNC, V_BP, V_ACTIVE, V_FP);
    // +1 so the exclusive end bounds below always fit the counter width
    localparam int unsigned HW = $clog2(H_TOTAL + 1);
    localparam int unsigned VW = $clog2(V_TOTAL + 1);

    localparam int unsigned H_ACT_BEG = H_SYNC + H_BP;
    localparam int unsigned H_ACT_END = H_ACT_BEG + H_ACTIVE;
    localparam int unsigned V_ACT_BEG = V_SYNC + V_BP;
    localparam int unsigned V_ACT_END = V_ACT_BEG + V_ACTIVE;

    logic [HW-1:0] hcnt;
    logic [VW-1:0] vcnt;
    logic          h_act;
    logic          v_act;

    // Line/frame counters
    always_ff @(posedge clk) begin
        if (!rstn) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (hcnt == HW'(H_TOTAL - 1)) begin
            hcnt <= '0;
            if (vcnt == VW'(V_TOTAL - 1)) begin
                vcnt <= '0;
            end else begin
                vcnt <= vcnt + VW'(1);
            end
        end else begin
            hcnt <= hcnt + HW'(1);
        end
    end

    // Region decodes
    always_comb begin
        h_act         = (hcnt >= HW'(H_ACT_BEG)) && (hcnt < HW'(H_ACT_END));
        v_act         = (vcnt >= VW'(V_ACT_BEG)) && (vcnt < VW'(V_ACT_END));
        active_c      = h_act && v_act;
        line_first_c  = (hcnt == HW'(H_ACT_BEG));
        line_last_c   = (hcnt == HW'(H_ACT_END - 1));
        hs_c          = (hcnt < HW'(H_SYNC)) ? SYNC_POL : ~SYNC_POL;
        vs_c          = (vcnt < VW'(V_SYNC)) ? SYNC_POL : ~SYNC_POL;
        frame_start_c = (hcnt == '0) && (vcnt == '0);
    end

endmodule

// File: rtl/vga_fb_scanout.sv
// vga_fb_scanout: VGA scan-out engine fetching pixels from a framebuffer RAM.
//   clk, rstn    pixel clock, synchronous active-low reset
//   fb_base      word address of pixel (0,0), latched at frame start
//   mem_data     RAM read data, valid RD_LAT clocks after mem_en
//   mem_en       RAM read enable (visible region, counter stage)
//   mem_addr     RAM read address
//   hs, vs, de   sync / data-enable, RD_LAT+1 clocks after the counter stage
//   rgb          pixel colour (mem_data[11:0]), 0 outside de
//   frame_start  one-clock pulse at hcnt = 0, vcnt = 0 (counter stage)
// Optional build macro VGA_SCANOUT_TEST_PATTERN_EN adds tp_en, which (latched
// at frame start) replaces fetched pixels with 8 vertical colour bars.
module vga_fb_scanout
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_SYNC   = H_SYNC_DEF,
    parameter int unsigned H_BP     = H_BP_DEF,
    parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
    parameter int unsigned H_FP     = H_FP_DEF,
    parameter int unsigned V_SYNC   = V_SYNC_DEF,
    parameter int unsigned V_BP     = V_BP_DEF,
    parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
    parameter int unsigned V_FP     = V_FP_DEF,
    parameter bit          SYNC_POL = 1'b1,
    parameter int unsigned SCALE    = 1,
    parameter int unsigned RD_LAT   = 1,
    parameter int unsigned ADDR_W   = 19,
    parameter int unsigned DATA_W   = 16
) (
    input  logic              clk,
    input  logic              rstn,
`ifdef VGA_SCANOUT_TEST_PATTERN_EN
    input  logic              tp_en,
`endif
    input  logic [ADDR_W-1:0] fb_base,
    input  logic [DATA_W-1:0] mem_data,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              hs,
    output logic              vs,
    output logic              de,
    output logic [RGB_W-1:0]  rgb,
    output logic              frame_start
);

    localparam int unsigned FB_W = H_ACTIVE / SCALE;
    // de_pipe[0] is the counter stage; de_pipe[RD_LAT] lines up with mem_data
    localparam int unsigned PD   = RD_LAT + 2;

    // Elaboration-time parameter checks
    if ((SCALE != 1) && (SCALE != 2) && (SCALE != 4)) begin : g_bad_scale
        $error("vga_fb_scanout: SCALE must be 1, 2 or 4");
    end
    if (((H_ACTIVE % SCALE) != 0) || ((V_ACTIVE % SCALE) != 0)) begin : g_bad_div
        $error("vga_fb_scanout: H_ACTIVE and V_ACTIVE must be divisible by SCALE");
    end
    if ((RD_LAT == 0) || (RD_LAT > 4)) begin : g_bad_lat
        $error("vga_fb_scanout: RD_LAT must be in 1..4");
    end
    if (DATA_W < RGB_W) begin : g_bad_data
        $error("vga_fb_scanout: DATA_W must be at least 12");
    end

    logic active_c;
    logic line_first_c;
    logic line_last_c;
    logic hs_c;
    logic vs_c;
    logic frame_start_c;
    logic fetch_c;
    logic [RGB_W-1:0] pix_c;

    logic [PD-1:0]     de_pipe;
    logic [PD-1:0]     hs_pipe;
    logic [PD-1:0]     vs_pipe;
    logic [1:0]        x_rep;
    logic [1:0]        y_rep;
    // Holds the frame base from frame start, then the first word of each
    // source line as the frame advances.
    logic [ADDR_W-1:0] line_addr;

    // Upper data bits carry no colour
    logic unused_mem_bits;
    assign unused_mem_bits = ^mem_data;

    vga_timing_gen #(
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .SYNC_POL (SYNC_POL)
    ) u_timing (
        .clk           (clk),
        .rstn          (rstn),
        .active_c      (active_c),
        .line_first_c  (line_first_c),
        .line_last_c   (line_last_c),
        .hs_c          (hs_c),
        .vs_c          (vs_c),
        .frame_start_c (frame_start_c)
    );

`ifdef VGA_SCANOUT_TEST_PATTERN_EN
    localparam int unsigned BAR_W = H_ACTIVE / N_BARS;
    localparam int unsigned BCW   = $clog2(BAR_W + 1);

    if (H_ACTIVE < N_BARS) begin : g_bad_bars
        $error("vga_fb_scanout: H_ACTIVE too small for the colour-bar pattern");
    end

    logic             tp_q;
    logic [2:0]       bar_idx;
    logic [BCW-1:0]   bar_cnt;
    logic [2:0]       bar_idx_c;
    logic [BCW-1:0]   bar_cnt_c;
    logic [RD_LAT:0]  tp_pipe;
    logic [RGB_W-1:0] bar_pipe [RD_LAT+1];

    // Bar position of the pixel issued at this counter-stage edge
    always_comb begin
        bar_idx_c = bar_idx;
        bar_cnt_c = bar_cnt + BCW'(1);
        if (line_first_c) begin
            bar_idx_c = '0;
            bar_cnt_c = '0;
        end else if (bar_cnt == BCW'(BAR_W - 1)) begin
            bar_cnt_c = '0;
            // Saturate on the last bar if H_ACTIVE is not a multiple of 8
            bar_idx_c = (bar_idx == 3'd7) ? bar_idx : bar_idx + 3'd1;
        end
    end

    // Pattern enable latch and colour pipeline matching the RAM latency
    always_ff @(posedge clk) begin
        if (!rstn) begin
            tp_q    <= 1'b0;
            bar_idx <= '0;
            bar_cnt <= '0;
            tp_pipe <= '0;
            for (int i = 0; i <= int'(RD_LAT); i++) begin
                bar_pipe[i] <= '0;
            end
        end else begin
            if (frame_start_c) begin
                tp_q <= tp_en;
            end
            if (active_c) begin
                bar_idx <= bar_idx_c;
                bar_cnt <= bar_cnt_c;
            end
            tp_pipe     <= {tp_pipe[RD_LAT-1:0], tp_q};
            bar_pipe[0] <= bar_colour(bar_idx_c);
            for (int i = 1; i <= int'(RD_LAT); i++) begin
                bar_pipe[i] <= bar_pipe[i-1];
            end
        end
    end

    assign fetch_c = active_c && !tp_q;

    always_comb begin
        pix_c = mem_data[RGB_W-1:0];
        if (tp_pipe[RD_LAT]) begin
            pix_c = bar_pipe[RD_LAT];
        end
    end
`else
    assign fetch_c = active_c;
    assign pix_c   = mem_data[RGB_W-1:0];
`endif

    // Counter stage (address generation) and output delay line
    always_ff @(posedge clk) begin
        if (!rstn) begin
            frame_start <= 1'b0;
            mem_en      <= 1'b0;
            mem_addr    <= '0;
            line_addr   <= '0;
            x_rep       <= '0;
            y_rep       <= '0;
            de_pipe     <= '0;
            hs_pipe     <= {PD{~SYNC_POL}};
            vs_pipe     <= {PD{~SYNC_POL}};
            rgb         <= '0;
        end else begin
            frame_start <= frame_start_c;
            mem_en      <= fetch_c;

            if (frame_start_c) begin
                line_addr <= fb_base;
                y_rep     <= '0;
            end

            if (active_c) begin
                // Horizontal replication: advance after SCALE issues
                if (line_first_c) begin
                    mem_addr <= line_addr;
                    x_rep    <= '0;
                end else if (x_rep == 2'(SCALE - 1)) begin
                    mem_addr <= mem_addr + ADDR_W'(1);
                    x_rep    <= '0;
                end else begin
                    x_rep <= x_rep + 2'd1;
                end

                // Vertical replication: step to the next source line after
                // SCALE output lines, otherwise replay the same one
                if (line_last_c) begin
                    if (y_rep == 2'(SCALE - 1)) begin
                        y_rep     <= '0;
                        line_addr <= line_addr + ADDR_W'(FB_W);
                    end else begin
                        y_rep <= y_rep + 2'd1;
                    end
                end
            end

            de_pipe <= {de_pipe[PD-2:0], active_c};
            hs_pipe <= {hs_pipe[PD-2:0], hs_c};
            vs_pipe <= {vs_pipe[PD-2:0], vs_c};
            rgb     <= de_pipe[RD_LAT] ? pix_c : RGB_W'(0);
        end
    end

    assign de = de_pipe[PD-1];
    assign hs = hs_pipe[PD-1];
    assign vs = vs_pipe[PD-1];

endmodule

// File: tb/tb_vga_fb_scanout.sv
// Directed bench for vga_fb_scanout using a reduced mode (17 x 9 totals,
// 8 x 4 visible). Two instances: SCALE=1/RD_LAT=1/positive sync and
// SCALE=2/RD_LAT=3/negative sync, each with its own latency-matched RAM.
module tb_vga_fb_scanout;

    localparam int HT   = 17;          // 4 + 3 + 8 + 2
    localparam int VT   = 9;           // 2 + 2 + 4 + 1
    localparam int FT   = HT * VT;
    localparam int HBEG = 7;
    localparam int VBEG = 4;
    localparam int HACT = 8;
    localparam int VACT = 4;

    logic        clk = 1'b0;
    logic        rstn;
    logic [18:0] fb_base;

    logic [15:0] mem_data1, mem_data2;
    logic        mem_en1, mem_en2;
    logic [18:0] mem_addr1, mem_addr2;
    logic        hs1, vs1, de1, fs1;
    logic        hs2, vs2, de2, fs2;
    logic [11:0] rgb1, rgb2;
    logic [15:0] r2a, r2b;

    int          pass_cnt = 0;
    int          fail_cnt = 0;
    int          tot_cnt  = 0;
    int          cur_t    = 0;
    int          en_cnt1  = 0;
    int          en_cnt2  = 0;
    logic [18:0] exp_base [4];

    always #5 clk = ~clk;

    vga_fb_scanout #(
        .H_SYNC(4), .H_BP(3), .H_ACTIVE(8), .H_FP(2),
        .V_SYNC(2), .V_BP(2), .V_ACTIVE(4), .V_FP(1),
        .SYNC_POL(1'b1), .SCALE(1), .RD_LAT(1), .ADDR_W(19), .DATA_W(16)
    ) dut1 (
        .clk(clk), .rstn(rstn), .fb_base(fb_base), .mem_data(mem_data1),
        .mem_en(mem_en1), .mem_addr(mem_addr1), .hs(hs1), .vs(vs1),
        .de(de1), .rgb(rgb1), .frame_start(fs1)
    );

    vga_fb_scanout #(
        .H_SYNC(4), .H_BP(3), .H_ACTIVE(8), .H_FP(2),
        .V_SYNC(2), .V_BP(2), .V_ACTIVE(4), .V_FP(1),
        .SYNC_POL(1'b0), .SCALE(2), .RD_LAT(3), .ADDR_W(19), .DATA_W(16)
    ) dut2 (
        .clk(clk), .rstn(rstn), .fb_base(fb_base), .mem_data(mem_data2),
        .mem_en(mem_en2), .mem_addr(mem_addr2), .hs(hs2), .vs(vs2),
        .de(de2), .rgb(rgb2), .frame_start(fs2)
    );

    function automatic logic [11:0] ram12(input logic [18:0] a);
        return a[11:0] ^ 12'h5A7;
    endfunction

    function automatic logic [15:0] ram_word(input logic [18:0] a);
        return {4'hC, ram12(a)};
    endfunction

    // RAM models: latency 1 and latency 3; 16'hBEEF when not enabled
    always @(posedge clk) begin
        mem_data1 <= mem_en1 ? ram_word(mem_addr1) : 16'hBEEF;
    end

    always @(posedge clk) begin
        r2a       <= mem_en2 ? ram_word(mem_addr2) : 16'hBEEF;
        r2b       <= r2a;
        mem_data2 <= r2b;
    end

    function automatic logic pos_active(input int p);
        int h, v;
        h = p % HT;
        v = (p / HT) % VT;
        return (h >= HBEG) && (h < HBEG + HACT) && (v >= VBEG) && (v < VBEG + VACT);
    endfunction

    function automatic logic [18:0] pos_addr(input int p, input int s);
        int h, v, fr;
        h  = p % HT;
        v  = (p / HT) % VT;
        fr = p / FT;
        if (fr > 3) fr = 3;
        return exp_base[fr] + 19'((((v - VBEG) / s) * (HACT / s)) + ((h - HBEG) / s));
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tot_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s t=%0d: observed %0h expected %0h", tag, cur_t, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input int po, input int s, input logic pol,
                             input logic de_o, input logic hs_o, input logic vs_o,
                             input logic [11:0] rgb_o);
        logic de_e, hs_e, vs_e;
        logic [11:0] rgb_e;
        if (po < 0) begin
            de_e  = 1'b0;
            hs_e  = ~pol;
            vs_e  = ~pol;
            rgb_e = 12'h000;
        end else begin
            de_e  = pos_active(po);
            hs_e  = ((po % HT) < 4) ? pol : ~pol;
            vs_e  = (((po / HT) % VT) < 2) ? pol : ~pol;
            rgb_e = de_e ? ram12(pos_addr(po, s)) : 12'h000;
        end
        chk({tag, "_de"},  32'(de_o),  32'(de_e));
        chk({tag, "_hs"},  32'(hs_o),  32'(hs_e));
        chk({tag, "_vs"},  32'(vs_o),  32'(vs_e));
        chk({tag, "_rgb"}, 32'(rgb_o), 32'(rgb_e));
    endtask

    // t = rising edges since rstn went high; counter stage of edge t is p = t-1
    task automatic check_cycle(input int t);
        int p0;
        p0    = t - 1;
        cur_t = t;
        chk("mem_en1", 32'(mem_en1), 32'(pos_active(p0)));
        chk("mem_en2", 32'(mem_en2), 32'(pos_active(p0)));
        if (pos_active(p0)) begin
            chk("mem_addr1", 32'(mem_addr1), 32'(pos_addr(p0, 1)));
            chk("mem_addr2", 32'(mem_addr2), 32'(pos_addr(p0, 2)));
        end
        chk("frame_start1", 32'(fs1), 32'((p0 % FT) == 0));
        chk("frame_start2", 32'(fs2), 32'((p0 % FT) == 0));
        check_out("d1", t - 3, 1, 1'b1, de1, hs1, vs1, rgb1);
        check_out("d2", t - 5, 2, 1'b0, de2, hs2, vs2, rgb2);
    endtask

    task automatic check_reset();
        chk("rst_mem_en1",   32'(mem_en1),   32'd0);
        chk("rst_mem_en2",   32'(mem_en2),   32'd0);
        chk("rst_mem_addr1", 32'(mem_addr1), 32'd0);
        chk("rst_mem_addr2", 32'(mem_addr2), 32'd0);
        chk("rst_fs1",       32'(fs1),       32'd0);
        chk("rst_fs2",       32'(fs2),       32'd0);
        check_out("rst_d1", -1, 1, 1'b1, de1, hs1, vs1, rgb1);
        check_out("rst_d2", -1, 2, 1'b0, de2, hs2, vs2, rgb2);
    endtask

    initial begin
        rstn     = 1'b0;
        fb_base  = 19'h01000;
        exp_base = '{19'h01000, 19'h08000, 19'h7FFFC, 19'h7FFFC};

        // Reset state
        repeat (3) begin
            @(negedge clk);
            check_reset();
        end

        // Three frames: base 0x1000, then 0x8000 (changed mid-frame 0),
        // then 0x7FFFC (changed mid-frame 1, addresses wrap past 2^19)
        rstn = 1'b1;
        for (int t = 1; t <= 539; t++) begin
            @(negedge clk);
            check_cycle(t);
            if (t <= FT) begin
                en_cnt1 += int'(mem_en1);
                en_cnt2 += int'(mem_en2);
            end
            if (t == 100) fb_base = 19'h08000;
            if (t == 250) fb_base = 19'h7FFFC;
        end
        cur_t = 0;
        chk("en_count1", 32'(en_cnt1), 32'd32);
        chk("en_count2", 32'(en_cnt2), 32'd32);

        // Reset in the middle of a visible line (edge 539 issued a pixel)
        rstn = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check_reset();
        end

        fb_base  = 19'h00200;
        exp_base = '{19'h00200, 19'h00200, 19'h00200, 19'h00200};
        rstn     = 1'b1;
        for (int t = 1; t <= 160; t++) begin
            @(negedge clk);
            check_cycle(t);
        end

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule

// File: doc/vga_fb_scanout.md
Name: vga_fb_scanout

Overview:
- Parametrised VGA scan-out engine. Generates sync and data-enable timing for any mode.
- Fetches pixels from a synchronous framebuffer RAM with a configurable read latency.
- Supports integer pixel replication (SCALE) and a frame base address latched once per frame for double buffering.
- Sits between the framebuffer RAM port and the VGA DAC pins; replaces fixed 640x480 scan-out.

Parameters:
- H_SYNC, 96, horizontal sync width (pixel clocks)
- H_BP, 48, horizontal back porch
- H_ACTIVE, 640, horizontal visible pixels
- H_FP, 16, horizontal front porch
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch
- SYNC_POL, 1, sync asserted level (1 = high during sync)
- SCALE, 1, pixel/line replication factor (1, 2 or 4); FB_W = H_ACTIVE/SCALE
- RD_LAT, 1, RAM read latency in clocks (1..4)
- ADDR_W, 19, framebuffer address width
- DATA_W, 16, framebuffer word width; rgb = mem_data[11:0]

Ports:
- clk  in  1  pixel clock
- rstn  in  1  synchronous active-low reset
- fb_base  in  ADDR_W  word address of frame pixel (0,0); sampled at frame start
- mem_data  in  DATA_W  RAM read data, valid RD_LAT clocks after mem_en
- mem_en  out  1  RAM read enable
- mem_addr  out  ADDR_W  RAM read address
- hs  out  1  horizontal sync
- vs  out  1  vertical sync
- de  out  1  visible-pixel enable, aligned with rgb
- rgb  out  12  pixel colour, 0 outside de
- frame_start  out  1  one-clock pulse when hcnt=0 and vcnt=0 (counter stage)

Behaviour:
- Reset is synchronous and active-low. Clock is clk, reset is rstn.
- Counters:
  - H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP; hcnt counts 0..H_TOTAL-1 and wraps.
  - vcnt increments when hcnt = H_TOTAL-1 and wraps at V_TOTAL-1.
  - Line order: sync, back porch, active, front porch. Sync is asserted for hcnt < H_SYNC (vcnt < V_SYNC).
- Active region: H_SYNC+H_BP <= hcnt < H_SYNC+H_BP+H_ACTIVE, with the same rule for vcnt. mem_en = 1 exactly in the active region, at the counter stage.
- Address generation (no multiplier):
  - At frame_start: base_q <= fb_base and line_addr <= fb_base. fb_base is ignored at all other times.
  - Within an active line: mem_addr starts at line_addr. An x_rep counter (0..SCALE-1) advances mem_addr by 1 when it wraps.
  - After each active line, y_rep (0..SCALE-1) increments. On y_rep wrap, line_addr += FB_W; otherwise line_addr is unchanged, so the line repeats.
  - Arithmetic is modulo 2^ADDR_W; wrap is silent.
- Output pipeline:
  - hs, vs and de are delayed RD_LAT+1 clocks from the counter stage through a shift register.
  - rgb is registered as de_pipe[RD_LAT] ? mem_data[11:0] : 0.
  - All outputs are registered, so pixel N appears RD_LAT+1 clocks after its mem_en.
- Reset values: hcnt=0, vcnt=0, x_rep=y_rep=0, mem_en=0, mem_addr=0, de=0, rgb=0, frame_start=0. hs and vs sit at ~SYNC_POL. The pipeline is flushed to the inactive state.
- Reset mid-frame: on the first clock with rstn=1, counting restarts at hcnt=0/vcnt=0 and frame_start pulses. No stale pixel reaches rgb.
- Illegal parameters (H_ACTIVE or V_ACTIVE not divisible by SCALE, RD_LAT outside 1..4) stop elaboration with $error.

Optional Feature:
- Macro: VGA_SCANOUT_TEST_PATTERN_EN.
- Defined:
  - Adds input port tp_en (1 bit), sampled at frame_start.
  - While the latched tp_en = 1: mem_en is forced to 0; rgb shows 8 vertical colour bars of width H_ACTIVE/8, in the order white, yellow, cyan, green, magenta, red, blue, black (12'hFFF, FF0, 0FF, 0F0, F0F, F00, 00F, 000).
  - Timing and latency are identical to normal mode.
- Undefined: no tp_en port and no pattern logic.

Decomposition:
- Shared include/package vga_timing_pkg holds:
  - default 640x480@60 constants (sync/porch/active values);
  - derived H_TOTAL and V_TOTAL functions;
  - the colour-bar constant table.
- One sub-module, vga_timing_gen, contains hcnt/vcnt, the active flags, raw hs/vs and frame_start. Parameters are the timing set.
- Address generator and output pipeline stay in vga_fb_scanout.

Test Plan:
- Default params, RD_LAT=1, SCALE=1: 2 frames → hs period 800 clocks, sync high 96; vs period 525 lines, high 2; exactly 307200 mem_en per frame; de rises 2 clocks after first mem_en.
- fb_base=19'h1000, SCALE=1 → first active mem_addr 0x1000, first of line 1 0x1280, last of frame 0x1000+307199; rgb equals mem_data[11:0] from model RAM, delayed 2 clocks.
- SCALE=2, fb_base=0 → addresses 0,0,1,1..319,319 on line 0; line 1 repeats 0..319; line 2 starts 320; 76800 distinct addresses per frame.
- RD_LAT=3 → rgb/de/hs/vs all shifted 4 clocks from the counter stage; pixel values still match addresses.
- Change fb_base mid-frame from 0 to 0x8000 → current frame keeps base 0; next frame starts at 0x8000 after the frame_start pulse.
- Assert rstn=0 for 3 clocks mid-active-line → outputs inactive (rgb=0, de=0, hs=vs=~SYNC_POL) on the next edge; after release, frame_start pulses and addressing restarts at fb_base.
